// File: rtl/uart_fifo.sv
// 16-entry first-word-fall-through FIFO for the 16550-style UART.
// Tracks fill count, sticky overrun/underrun and an aggregate line-error flag.
module uart_fifo #(
   parameter int fifo_width     = 8,
   parameter int fifo_depth     = 16,
   parameter int fifo_pointer_w = 4,
   parameter int fifo_counter_w = 5
) (
   input  logic                      clk,
   input  logic                      wb_rst_i,
   input  logic [fifo_width-1:0]     data_in,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      fifo_reset,
   input  logic                      reset_status,
   output logic [fifo_width-1:0]     data_out,
   output logic [fifo_counter_w-1:0] count,
   output logic                      overrun,
   output logic                      underrun,
   output logic                      error_bit
);

   localparam logic [fifo_pointer_w-1:0] ptr_one   = fifo_pointer_w'(1);
   localparam logic [fifo_counter_w-1:0] cnt_one   = fifo_counter_w'(1);
   localparam logic [fifo_counter_w-1:0] cnt_full  = fifo_counter_w'(fifo_depth);

   logic [fifo_width-1:0]     mem_q [fifo_depth];
   logic [fifo_width-1:0]     mem_d [fifo_depth];
   logic [fifo_pointer_w-1:0] top_q, top_d;
   logic [fifo_pointer_w-1:0] bottom_q, bottom_d;
   logic [fifo_counter_w-1:0] count_q, count_d;
   logic                      overrun_q, overrun_d;
   logic                      underrun_q, underrun_d;
   logic                      overrun_set;
   logic                      is_empty;
   logic                      is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == cnt_full);

   always_comb begin
      mem_d       = mem_q;
      top_d       = top_q;
      bottom_d    = bottom_q;
      count_d     = count_q;
      overrun_d   = overrun_q;
      underrun_d  = underrun_q;
      overrun_set = 1'b0;

      if (fifo_reset) begin
         for (int i = 0; i < fifo_depth; i++) begin
            mem_d[i] = '0;
         end
         top_d      = '0;
         bottom_d   = '0;
         count_d    = '0;
         overrun_d  = 1'b0;
         underrun_d = 1'b0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (!is_full) begin
                  mem_d[top_q] = data_in;
                  top_d        = top_q + ptr_one;
                  count_d      = count_q + cnt_one;
               end else begin
                  overrun_set = 1'b1;
                  overrun_d   = 1'b1;
               end
            end
            2'b01: begin
               if (!is_empty) begin
                  bottom_d = bottom_q + ptr_one;
                  count_d  = count_q - cnt_one;
               end else begin
                  underrun_d = 1'b1;
               end
            end
            2'b11: begin
               // At empty the write lands but the pop has nothing to remove.
               mem_d[top_q] = data_in;
               top_d        = top_q + ptr_one;
               if (!is_empty) begin
                  bottom_d = bottom_q + ptr_one;
               end else begin
                  count_d    = cnt_one;
                  underrun_d = 1'b1;
               end
            end
            default: begin
            end
         endcase

         if (reset_status && !overrun_set) begin
            overrun_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < fifo_depth; i++) begin
            mem_q[i] <= '0;
         end
         top_q      <= '0;
         bottom_q   <= '0;
         count_q    <= '0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         top_q      <= top_d;
         bottom_q   <= bottom_d;
         count_q    <= count_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
      end
   end

   // Only entries inside the occupied window [bottom, bottom+count) may raise the flag.
   logic [fifo_pointer_w-1:0] offset;
   logic                      error_acc;

   always_comb begin
      error_acc = 1'b0;
      offset    = '0;
      for (int i = 0; i < fifo_depth; i++) begin
         offset = fifo_pointer_w'(i) - bottom_q;
         if (fifo_counter_w'(offset) < count_q) begin
            error_acc = error_acc | (|mem_q[i][2:0]);
         end
      end
   end

   assign data_out  = mem_q[bottom_q];
   assign count     = count_q;
   assign overrun   = overrun_q;
   assign underrun  = underrun_q;
   assign error_bit = error_acc;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed self-checking bench for uart_fifo at receiver width (11 bits).
module tb_uart_fifo;

   localparam int W = 11;

   logic          clk;
   logic          wb_rst_i;
   logic [W-1:0]  data_in;
   logic          push;
   logic          pop;
   logic          fifo_reset;
   logic          reset_status;
   logic [W-1:0]  data_out;
   logic [4:0]    count;
   logic          overrun;
   logic          underrun;
   logic          error_bit;

   int checkCount;
   int failCount;

   uart_fifo #(
      .fifo_width     (W),
      .fifo_depth     (16),
      .fifo_pointer_w (4),
      .fifo_counter_w (5)
   ) dut (
      .clk          (clk),
      .wb_rst_i     (wb_rst_i),
      .data_in      (data_in),
      .push         (push),
      .pop          (pop),
      .fifo_reset   (fifo_reset),
      .reset_status (reset_status),
      .data_out     (data_out),
      .count        (count),
      .overrun      (overrun),
      .underrun     (underrun),
      .error_bit    (error_bit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-derived expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Hold the strobes for one rising edge, then release them 1ns later.
   task automatic applyStimulus(input logic doPush, input logic doPop, input logic [W-1:0] data,
                                input logic doFlush, input logic doClear);
      push         = doPush;
      pop          = doPop;
      data_in      = data;
      fifo_reset   = doFlush;
      reset_status = doClear;
      @(posedge clk);
      #1;
      push         = 1'b0;
      pop          = 1'b0;
      data_in      = '0;
      fifo_reset   = 1'b0;
      reset_status = 1'b0;
   endtask

   initial begin
      checkCount   = 0;
      failCount    = 0;
      wb_rst_i     = 1'b1;
      push         = 1'b0;
      pop          = 1'b0;
      data_in      = '0;
      fifo_reset   = 1'b0;
      reset_status = 1'b0;
      #12;
      wb_rst_i = 1'b0;

      checkOutput("reset_count", 32'(count), 0);
      checkOutput("reset_data", 32'(data_out), 0);
      checkOutput("reset_err", 32'(error_bit), 0);
      checkOutput("reset_ovr", 32'(overrun), 0);
      checkOutput("reset_unr", 32'(underrun), 0);

      // Fill to 16
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(1'b1, 1'b0, W'(i), 1'b0, 1'b0);
      end
      checkOutput("fill_count", 32'(count), 16);
      checkOutput("fill_head", 32'(data_out), 32'h001);
      checkOutput("fill_ovr", 32'(overrun), 0);
      checkOutput("fill_err", 32'(error_bit), 1);

      // Overrun and its clear, including set-wins
      applyStimulus(1'b1, 1'b0, 11'h7FF, 1'b0, 1'b0);
      checkOutput("ovr_count", 32'(count), 16);
      checkOutput("ovr_flag", 32'(overrun), 1);
      checkOutput("ovr_head", 32'(data_out), 32'h001);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      checkOutput("ovr_clear", 32'(overrun), 0);
      applyStimulus(1'b1, 1'b0, 11'h7FF, 1'b0, 1'b1);
      checkOutput("ovr_setwins", 32'(overrun), 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      checkOutput("ovr_clear2", 32'(overrun), 0);

      // Push and pop together while full
      applyStimulus(1'b1, 1'b1, 11'h3AA, 1'b0, 1'b0);
      checkOutput("pp_full_count", 32'(count), 16);
      checkOutput("pp_full_ovr", 32'(overrun), 0);
      checkOutput("pp_full_head", 32'(data_out), 32'h002);
      for (int i = 2; i <= 16; i++) begin
         checkOutput($sformatf("drain_%0d", i), 32'(data_out), 32'(i));
         applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      end
      checkOutput("drain_last", 32'(data_out), 32'h3AA);
      checkOutput("drain_last_count", 32'(count), 1);
      checkOutput("drain_last_err", 32'(error_bit), 1);
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checkOutput("drained_count", 32'(count), 0);
      checkOutput("drained_err", 32'(error_bit), 0);

      // Underrun and push+pop at empty
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checkOutput("unr_flag", 32'(underrun), 1);
      checkOutput("unr_count", 32'(count), 0);
      applyStimulus(1'b1, 1'b1, 11'h055, 1'b0, 1'b0);
      checkOutput("pp_empty_count", 32'(count), 1);
      checkOutput("pp_empty_data", 32'(data_out), 32'h055);
      checkOutput("pp_empty_unr", 32'(underrun), 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      checkOutput("unr_sticky", 32'(underrun), 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("flush_unr", 32'(underrun), 0);
      checkOutput("flush_count", 32'(count), 0);
      checkOutput("flush_data", 32'(data_out), 0);

      // Error flag tracking
      applyStimulus(1'b1, 1'b0, 11'h100, 1'b0, 1'b0);
      checkOutput("err_clean", 32'(error_bit), 0);
      applyStimulus(1'b1, 1'b0, 11'h101, 1'b0, 1'b0);
      checkOutput("err_framing", 32'(error_bit), 1);
      applyStimulus(1'b1, 1'b0, 11'h200, 1'b0, 1'b0);
      checkOutput("err_still", 32'(error_bit), 1);
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checkOutput("err_pop1", 32'(error_bit), 1);
      applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checkOutput("err_pop2", 32'(error_bit), 0);
      checkOutput("err_head", 32'(data_out), 32'h200);
      applyStimulus(1'b1, 1'b0, 11'h004, 1'b0, 1'b0);
      checkOutput("err_break", 32'(error_bit), 1);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      checkOutput("err_flush", 32'(error_bit), 0);

      // Pointer wrap across 15->0
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b0, W'(32'h020 + i), 1'b0, 1'b0);
      end
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("wrapA_%0d", i), 32'(data_out), 32'h020 + 32'(i));
         applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 1'b0, W'(32'h0A0 + i * 8), 1'b0, 1'b0);
      end
      checkOutput("wrap_count", 32'(count), 12);
      checkOutput("wrap_err_clean", 32'(error_bit), 0);
      for (int i = 0; i < 12; i++) begin
         checkOutput($sformatf("wrapB_%0d", i), 32'(data_out), 32'h0A0 + 32'(i * 8));
         applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
      end
      checkOutput("wrap_empty", 32'(count), 0);

      // Flush with a concurrent push
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, W'(32'h011 + i), 1'b0, 1'b0);
      end
      applyStimulus(1'b1, 1'b0, 11'h007, 1'b1, 1'b0);
      checkOutput("flushpush_count", 32'(count), 0);
      checkOutput("flushpush_err", 32'(error_bit), 0);
      checkOutput("flushpush_data", 32'(data_out), 0);

      // Asynchronous reset mid-stream
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, W'(32'h001 + i), 1'b0, 1'b0);
      end
      checkOutput("pre_async_count", 32'(count), 3);
      #2;
      wb_rst_i = 1'b1;
      #1;
      checkOutput("async_count", 32'(count), 0);
      checkOutput("async_err", 32'(error_bit), 0);
      checkOutput("async_data", 32'(data_out), 0);
      #1;
      wb_rst_i = 1'b0;
      applyStimulus(1'b1, 1'b0, 11'h155, 1'b0, 1'b0);
      checkOutput("post_async_count", 32'(count), 1);
      checkOutput("post_async_data", 32'(data_out), 32'h155);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Synchronous 16-entry first-word-fall-through FIFO for the 16550-style UART.
- The receiver instantiates it at 11-bit width (8 data bits + break/parity/framing flags) to buffer received characters for the register interface.
- It reports fill count, sticky overrun/underrun, and an aggregate line-error flag for LSR bit 7.
- It has a software flush input (fifo_reset) and an LSR-read status clear input (reset_status).

Parameters:
- fifo_width, 8, word width in bits. Receiver uses 11 (`UART_FIFO_REC_WIDTH). Must be >= 3 for error_bit to be meaningful.
- fifo_depth, 16, number of entries (fixed, power of two).
- fifo_pointer_w, 4, log2(fifo_depth).
- fifo_counter_w, 5, count width (`UART_FIFO_COUNTER_W), holds 0..16.

Ports:
- clk  in  1  clock, all state on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- data_in  in  fifo_width  word written on push.
- push  in  1  write strobe, one word per cycle high.
- pop  in  1  read strobe, removes head word.
- fifo_reset  in  1  synchronous flush.
- reset_status  in  1  synchronous clear of sticky overrun (LSR read).
- data_out  out  fifo_width  head entry, combinational, valid whenever count>0.
- count  out  fifo_counter_w  number of stored words, 0..16.
- overrun  out  1  sticky: push attempted while full.
- underrun  out  1  sticky: pop attempted while empty.
- error_bit  out  1  OR of bits[2:0] of all currently stored entries.

Behaviour:
- Storage: 16 x fifo_width array, write pointer top, read pointer bottom (4 bits each, natural wrap 15->0), and count.
- Reset (wb_rst_i=1, async): top=0, bottom=0, count=0, overrun=0, underrun=0, all entries cleared to 0. Outputs become data_out=0, error_bit=0.
- Priority per clock edge: fifo_reset, then the push/pop case, then reset_status.
- fifo_reset=1: same clearing as wb_rst_i, but synchronous. Any push/pop in that cycle is ignored.
- push only, count<16: mem[top]<=data_in; top+1; count+1.
- push only, count==16: word dropped; pointers and count unchanged; overrun<=1.
- pop only, count>0: bottom+1; count-1. The vacated entry's error bits stop contributing.
- pop only, count==0: nothing changes; underrun<=1.
- push and pop, count>0 (including full): write at top and advance both pointers; count unchanged; no overrun.
- push and pop, count==0: the write is accepted; count becomes 1; the pop is ignored; underrun<=1.
- reset_status=1: overrun<=0. If a push into a full FIFO occurs in the same cycle, overrun stays 1 (set wins).
- underrun clears only on wb_rst_i or fifo_reset.
- data_out = mem[bottom] combinationally, so the new head is visible the cycle after a pop (zero-latency FWFT). Undefined-content free entries must never affect error_bit.
- error_bit:
  - Combinational OR over entries i in [bottom, bottom+count) of mem[i][2:0].
  - Goes high the cycle after an erroneous word is pushed.
  - Drops the cycle after the last erroneous word is popped.
- Counter: count never exceeds 16 and never wraps below 0.
- No reads/writes beyond the 16-entry array under any strobe combination.

Test Plan:
- Reset then fill: push 0x001,0x002..0x010 on 16 consecutive cycles -> count=16, data_out=0x001, overrun=0; then pop 16 times -> data_out steps 0x002..0x010, count=0.
- Overrun: with count=16, push 0x7FF -> count=16, overrun=1, sequence unchanged. Assert reset_status one cycle -> overrun=0.
- Underrun: at count=0, pop -> underrun=1, count=0. Push+pop together at count=0 with data 0x055 -> count=1, data_out=0x055. fifo_reset -> underrun=0, count=0.
- Error flag: push 0x100 (clean), 0x101 (framing), 0x200 (clean) -> error_bit=1 after the second push. Pop twice -> error_bit=0. Push 0x004 (break) -> error_bit=1.
- Simultaneous push/pop at full: count=16, push 0x3AA with pop -> count stays 16, overrun=0, head advances, 0x3AA is last out after 16 pops.
- Pointer wrap and flush: push 10, pop 10, push 12 -> count=12, order preserved across 15->0 wrap. fifo_reset with push asserted -> count=0, error_bit=0, pushed word discarded. Async wb_rst_i mid-stream -> immediate count=0.
